mips_encode: RTL and testbench

//  Inverse of mips_decode: accepts control fields (alu_op, alu_src2, regs, imm), emits the
//  32-bit MIPS arithmetic instruction word plus a sequential imem write address. Used by
//  the test loader to build programs for the Lab4 datapath. Valid/ready on both sides,
//  one output register stage, address counter, reject/error reporting.

---
 rtl/mips_encode.sv | 147 ++++++++++++++
 tb/tb_mips_encode.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_encode.sv
// rtl/mips_encode.sv - MIPS arithmetic instruction encoder with addressed output stage
//
// Purpose: turns ALU control fields into a 32-bit MIPS R/I-type word and tags it with
//   a sequential instruction-memory word address. One output register stage with
//   valid/ready on both sides. Unencodable requests are consumed and reported.
// Configuration macro: MIPS_ENCODE_NOP_PAD_EN -- when defined, rejected requests emit
//   32'h00000000 through the output path instead of being dropped.
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   request handshake
//   alu_op, alu_src2      operation selector (alu_src2: 00 reg, 01 sext imm, 10 zext imm)
//   rd, rs, rt, imm       register and immediate fields
//   out_valid / out_ready output handshake
//   out_inst, out_addr    encoded word and its imem word index
//   except                one-cycle pulse after a rejected request
//   err_sticky, err_clr   sticky reject flag and its clear
//   inst_count            saturating count of output transfers
module mips_encode #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        alu_op,
  input  logic [1:0]        alu_src2,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [15:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              except,
  output logic              err_sticky,
  input  logic              err_clr,
  output logic [15:0]       inst_count
);

  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_inst_q, out_inst_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic              except_q, except_d;
  logic              err_sticky_q, err_sticky_d;
  logic [15:0]       inst_count_q, inst_count_d;

  logic              legal;
  logic [31:0]       enc_word;
  logic              accept;
  logic              xfer;
  logic              load;

  // Field encoder: R-type places rd in [15:11] with a funct; I-type places rd in [20:16].
  always_comb begin
    legal    = 1'b1;
    enc_word = 32'h0000_0000;
    unique case ({alu_src2, alu_op})
      5'b00_010: enc_word = {6'h00, rs, rt, rd, 5'b0, 6'h20};
      5'b00_000: enc_word = {6'h00, rs, rt, rd, 5'b0, 6'h21};
      5'b00_011: enc_word = {6'h00, rs, rt, rd, 5'b0, 6'h22};
      5'b00_100: enc_word = {6'h00, rs, rt, rd, 5'b0, 6'h24};
      5'b00_101: enc_word = {6'h00, rs, rt, rd, 5'b0, 6'h25};
      5'b00_111: enc_word = {6'h00, rs, rt, rd, 5'b0, 6'h26};
      5'b00_110: enc_word = {6'h00, rs, rt, rd, 5'b0, 6'h27};
      5'b01_010: enc_word = {6'h08, rs, rd, imm};
      5'b01_000: enc_word = {6'h09, rs, rd, imm};
      5'b10_100: enc_word = {6'h0C, rs, rd, imm};
      5'b10_101: enc_word = {6'h0D, rs, rd, imm};
      5'b10_111: enc_word = {6'h0E, rs, rd, imm};
      default: begin
        legal    = 1'b0;
        enc_word = 32'h0000_0000;
      end
    endcase
  end

  // Ready depends only on the output register, so no comb path from in_* to out_*.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid_q && out_ready;

`ifdef MIPS_ENCODE_NOP_PAD_EN
  // Rejects become a nop word (enc_word is already zero for illegal combos).
  assign load = accept;
`else
  assign load = accept && legal;
`endif

  always_comb begin
    out_valid_d  = out_valid_q;
    out_inst_d   = out_inst_q;
    out_addr_d   = out_addr_q;
    inst_count_d = inst_count_q;
    except_d     = accept && !legal;
    err_sticky_d = err_sticky_q;

    if (xfer) begin
      out_valid_d = 1'b0;
      // The address register always names the word currently (or next) held.
      out_addr_d  = out_addr_q + ADDR_W'(1);
      if (inst_count_q != 16'hFFFF) begin
        inst_count_d = inst_count_q + 16'd1;
      end
    end

    if (load) begin
      out_valid_d = 1'b1;
      out_inst_d  = enc_word;
    end

    // A new reject outranks a clear in the same cycle.
    if (err_clr) begin
      err_sticky_d = 1'b0;
    end
    if (accept && !legal) begin
      err_sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_inst_q   <= 32'h0000_0000;
      out_addr_q   <= ADDR_W'(BASE_ADDR);
      except_q     <= 1'b0;
      err_sticky_q <= 1'b0;
      inst_count_q <= 16'h0000;
    end else begin
      out_valid_q  <= out_valid_d;
      out_inst_q   <= out_inst_d;
      out_addr_q   <= out_addr_d;
      except_q     <= except_d;
      err_sticky_q <= err_sticky_d;
      inst_count_q <= inst_count_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_inst   = out_inst_q;
  assign out_addr   = out_addr_q;
  assign except     = except_q;
  assign err_sticky = err_sticky_q;
  assign inst_count = inst_count_q;

endmodule

// File: tb/tb_mips_encode.sv
// tb/tb_mips_encode.sv - directed self-checking bench for mips_encode (ADDR_W=2)
module tb_mips_encode;

  localparam int AW = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    alu_op = 3'd0;
  logic [1:0]    alu_src2 = 2'd0;
  logic [4:0]    rd = 5'd0, rs = 5'd0, rt = 5'd0;
  logic [15:0]   imm = 16'd0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_inst;
  logic [AW-1:0] out_addr;
  logic          except;
  logic          err_sticky;
  logic          err_clr = 1'b0;
  logic [15:0]   inst_count;

  int n_cmp = 0;
  int n_err = 0;

`ifdef MIPS_ENCODE_NOP_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  mips_encode #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_op     (alu_op),
    .alu_src2   (alu_src2),
    .rd         (rd),
    .rs         (rs),
    .rt         (rt),
    .imm        (imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_inst   (out_inst),
    .out_addr   (out_addr),
    .except     (except),
    .err_sticky (err_sticky),
    .err_clr    (err_clr),
    .inst_count (inst_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic req(input logic [1:0] s2, input logic [2:0] op, input logic [4:0] d,
                     input logic [4:0] s, input logic [4:0] t, input logic [15:0] im);
    in_valid = 1'b1;
    alu_src2 = s2;
    alu_op   = op;
    rd       = d;
    rs       = s;
    rt       = t;
    imm      = im;
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset     = 1'b1;
    in_valid  = 1'b0;
    err_clr   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    @(negedge clock);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_inst", out_inst, 32'd0);
    check("rst_out_addr", {30'b0, out_addr}, 32'd0);
    check("rst_except", {31'b0, except}, 32'd0);
    check("rst_err_sticky", {31'b0, err_sticky}, 32'd0);
    check("rst_inst_count", {16'b0, inst_count}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // Single add
    out_ready = 1'b1;
    step();
    req(2'b00, 3'b010, 5'd3, 5'd1, 5'd2, 16'd0);
    step();
    in_valid = 1'b0;
    @(negedge clock);
    check("add_valid", {31'b0, out_valid}, 32'd1);
    check("add_inst", out_inst, 32'h0022_1820);
    check("add_addr", {30'b0, out_addr}, 32'd0);
    step();
    @(negedge clock);
    check("add_count", {16'b0, inst_count}, 32'd1);
    check("add_drained", {31'b0, out_valid}, 32'd0);

    // Back-to-back addi / ori
    do_reset();
    out_ready = 1'b1;
    req(2'b01, 3'b010, 5'd5, 5'd4, 5'd0, 16'hFFFF);
    @(negedge clock);
    check("b2b_ready0", {31'b0, in_ready}, 32'd1);
    step();
    req(2'b10, 3'b101, 5'd7, 5'd0, 5'd0, 16'h1234);
    @(negedge clock);
    check("b2b_inst0", out_inst, 32'h2085_FFFF);
    check("b2b_addr0", {30'b0, out_addr}, 32'd0);
    check("b2b_ready1", {31'b0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    @(negedge clock);
    check("b2b_inst1", out_inst, 32'h3407_1234);
    check("b2b_addr1", {30'b0, out_addr}, 32'd1);
    step();
    @(negedge clock);
    check("b2b_count", {16'b0, inst_count}, 32'd2);

    // Backpressure: nor held, second request stalls
    do_reset();
    out_ready = 1'b0;
    req(2'b00, 3'b110, 5'd8, 5'd9, 5'd10, 16'd0);
    step();
    req(2'b00, 3'b010, 5'd3, 5'd1, 5'd2, 16'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("stall_valid", {31'b0, out_valid}, 32'd1);
      check("stall_inst", out_inst, 32'h012A_4027);
      check("stall_in_ready", {31'b0, in_ready}, 32'd0);
      step();
    end
    out_ready = 1'b1;
    @(negedge clock);
    check("rel_in_ready", {31'b0, in_ready}, 32'd1);
    check("rel_inst0", out_inst, 32'h012A_4027);
    check("rel_addr0", {30'b0, out_addr}, 32'd0);
    step();
    in_valid = 1'b0;
    @(negedge clock);
    check("rel_inst1", out_inst, 32'h0022_1820);
    check("rel_addr1", {30'b0, out_addr}, 32'd1);
    step();
    @(negedge clock);
    check("rel_count", {16'b0, inst_count}, 32'd2);

    // Reject handling
    do_reset();
    out_ready = 1'b1;
    req(2'b01, 3'b100, 5'd1, 5'd1, 5'd1, 16'h5555);
    @(negedge clock);
    check("rej_in_ready", {31'b0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    @(negedge clock);
    check("rej_except", {31'b0, except}, 32'd1);
    check("rej_sticky", {31'b0, err_sticky}, 32'd1);
    check("rej_out_valid", {31'b0, out_valid}, {31'b0, PAD});
    check("rej_out_inst", out_inst, 32'd0);
    check("rej_out_addr", {30'b0, out_addr}, 32'd0);
    step();
    @(negedge clock);
    check("rej_except_pulse", {31'b0, except}, 32'd0);
    check("rej_sticky_hold", {31'b0, err_sticky}, 32'd1);
    req(2'b11, 3'b000, 5'd0, 5'd0, 5'd0, 16'd0);
    err_clr = 1'b1;
    step();
    in_valid = 1'b0;
    err_clr  = 1'b0;
    @(negedge clock);
    check("clr_vs_set_sticky", {31'b0, err_sticky}, 32'd1);
    check("clr_vs_set_except", {31'b0, except}, 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    @(negedge clock);
    check("clr_sticky", {31'b0, err_sticky}, 32'd0);
    check("clr_except", {31'b0, except}, 32'd0);
    check("rej_final_addr", {30'b0, out_addr}, PAD ? 32'd2 : 32'd0);
    check("rej_final_count", {16'b0, inst_count}, PAD ? 32'd2 : 32'd0);

    // Address wrap with ADDR_W=2: five xori words
    do_reset();
    out_ready = 1'b1;
    req(2'b10, 3'b111, 5'd2, 5'd1, 5'd0, 16'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      if (i < 4) req(2'b10, 3'b111, 5'd2, 5'd1, 5'd0, 16'(i + 1));
      else       in_valid = 1'b0;
      @(negedge clock);
      check("wrap_inst", out_inst, 32'h3822_0000 | i);
      check("wrap_addr", {30'b0, out_addr}, i % 4);
    end
    step();
    @(negedge clock);
    check("wrap_count", {16'b0, inst_count}, 32'd5);
    check("wrap_addr_next", {30'b0, out_addr}, 32'd1);

    // Reset while a word is pending
    out_ready = 1'b0;
    req(2'b00, 3'b010, 5'd3, 5'd1, 5'd2, 16'd0);
    step();
    in_valid = 1'b0;
    @(negedge clock);
    check("mid_valid_pre", {31'b0, out_valid}, 32'd1);
    check("mid_addr_pre", {30'b0, out_addr}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clock);
    check("mid_valid", {31'b0, out_valid}, 32'd0);
    check("mid_addr", {30'b0, out_addr}, 32'd0);
    check("mid_count", {16'b0, inst_count}, 32'd0);
    check("mid_inst", out_inst, 32'd0);
    check("mid_in_ready", {31'b0, in_ready}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
